// File: rtl/startup_edge_monitor.sv
// startup_edge_monitor
// Synchronizes an asynchronous input, emits registered one-cycle pulses on its
// rising and falling edges, counts edges (saturating at 255) and tracks startup
// progress in a four-state FSM: IDLE -> COUNT -> READY, with a TOUT exit taken
// when no edge arrives within TIMEOUT cycles. READY and TOUT hold until clear
// or reset. Edge detection keeps running in every state.
module startup_edge_monitor #(
  parameter int unsigned SYNC_STAGES = 2,     // 2..4
  parameter int unsigned EDGE_COUNT  = 3,     // 1..255
  parameter int unsigned TIMEOUT     = 255,   // 0 disables the timeout
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i,
  input  logic       clear,
  output logic       pos_o,
  output logic       neg_o,
  output logic [7:0] edge_count,
  output logic       ready,
  output logic       timeout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_READY = 2'd2,
    ST_TOUT  = 2'd3
  } state_e;

  localparam logic [7:0]  EDGE_TARGET = 8'(EDGE_COUNT);
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);
  localparam logic        TIMEOUT_EN  = (TIMEOUT != 32'd0);

  // synchronizer, history and pulse registers
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pos_q;
  logic                   neg_q;

  // monitor registers
  logic [7:0]  cnt_q;
  logic [15:0] timer_q;
  state_e      state_q;
  logic        ready_q;
  logic        timeout_q;

  // next-value helpers for the FSM
  logic        edge_d;
  logic [7:0]  cnt_d;
  logic [15:0] timer_d;
  logic        cnt_hit_d;
  logic        tmo_hit_d;

  // The FSM reacts to the registered pulse, one cycle after it is visible.
  assign edge_d    = pos_q | neg_q;
  assign cnt_d     = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
  assign cnt_hit_d = (cnt_d >= EDGE_TARGET);
  assign timer_d   = timer_q + 16'd1;
  // With the timeout disabled the timer may wrap freely; the compare is gated.
  assign tmo_hit_d = TIMEOUT_EN && (timer_d == TIMEOUT_VAL);

  // Input synchronizer chain, history flop and registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      hist_q <= RESET_LEVEL;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i};
      hist_q <= sync_q[SYNC_STAGES-1];
      pos_q  <= sync_q[SYNC_STAGES-1] & ~hist_q;
      neg_q  <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  // Startup FSM with edge counter, idle timer and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      timer_q   <= 16'd0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else if (clear) begin
      // Restart the monitor; an edge arriving together with clear is dropped.
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      timer_q   <= 16'd0;
      ready_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COUNT: begin
          if (edge_d) begin
            // An edge always beats a coinciding timeout.
            cnt_q   <= cnt_d;
            timer_q <= 16'd0;
            if (cnt_hit_d) begin
              state_q <= ST_READY;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_COUNT;
            end
          end else begin
            timer_q <= timer_d;
            if (tmo_hit_d) begin
              state_q   <= ST_TOUT;
              timeout_q <= 1'b1;
            end else begin
              state_q <= state_q;
            end
          end
        end
        ST_READY: begin
          // Keep counting edges (saturating); the timer is frozen here.
          if (edge_d) begin
            cnt_q <= cnt_d;
          end else begin
            cnt_q <= cnt_q;
          end
        end
        ST_TOUT: begin
          // Terminal: count and timer frozen until clear or reset.
          state_q <= ST_TOUT;
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= 8'd0;
          timer_q   <= 16'd0;
          ready_q   <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign pos_o      = pos_q;
  assign neg_o      = neg_q;
  assign edge_count = cnt_q;
  assign ready      = ready_q;
  assign timeout    = timeout_q;
  assign state      = state_q;

endmodule
